// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and taken-branch hazards,
// a memory-wait watchdog FSM, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_busy, load_use, freeze;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign mem_busy = mem_req & ~mem_ready;
  assign load_use = ex_MemRead & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    freeze  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || !mem_req) begin
          // Completed, or the requester abandoned the access.
          state_d = RUN;
          wait_d  = 16'd0;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 16'd1;
          if (wait_q == 16'(TIMEOUT)) state_d = ERROR;
        end
      end
      ERROR:   freeze = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Freeze overrides everything; otherwise a taken branch squashes the wrong-path
  // ID instruction, which makes any load-use on it irrelevant.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (freeze) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (pc_stall)    stall_cnt_d = sat_inc(stall_cnt_q);
      if (if_id_flush) flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_q      <= 16'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = (state_q == ERROR);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; expected responses are queued by the
// driver and checked by an independent monitor on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] LU = 7'b1100100;
  localparam logic [6:0] BR = 7'b0010100;
  localparam logic [6:0] FZ = 7'b1101011;

  typedef struct packed {
    logic [6:0]       ctl;
    logic             to;
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_MemRead = 0, ex_branch_taken = 0;
  logic mem_req = 0, mem_ready = 0, cnt_clr = 0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t exp_q[$];
  int   id_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vid   = 0;
  bit   done  = 0;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic vec(input logic rv, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] exrd,
                     input logic mr, input logic br, input logic req, input logic rdy,
                     input logic clr, input logic [6:0] ectl, input logic eto,
                     input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rv; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_rd = exrd; ex_MemRead = mr; ex_branch_taken = br;
    mem_req = req; mem_ready = rdy; cnt_clr = clr;
    e.ctl = ectl; e.to = eto; e.s = es; e.f = ef;
    exp_q.push_back(e);
    id_q.push_back(vid);
    vid++;
  endtask

  // Monitor
  initial begin
    exp_t e;
    exp_t a;
    int   k;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        k = id_q.pop_front();
        a.ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
        a.to  = mem_timeout;
        a.s   = stall_cnt;
        a.f   = flush_cnt;
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL vec%0d: got ctl=%b to=%b stall=%0d flush=%0d, expected ctl=%b to=%b stall=%0d flush=%0d",
                   k, a.ctl, a.to, a.s, a.f, e.ctl, e.to, e.s, e.f);
        end
      end
    end
  end

  initial begin
    //   rst rs1  u1 rs2  u2 exrd mr br req rdy clr  ctl  to  s   f
    vec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 0,  0);  // 0 in reset
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 0,  0);  // 1 idle
    vec(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, LU, 0, 0,  0);  // 2 load-use rs1
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 1,  0);  // 3
    vec(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, Z,  0, 1,  0);  // 4 x0 never hazards
    vec(1, 5'd3, 1, 5'd7, 1, 5'd7, 1, 0, 0, 0, 0, LU, 0, 1,  0);  // 5 load-use rs2
    vec(1, 5'd3, 1, 5'd7, 0, 5'd7, 1, 0, 0, 0, 0, Z,  0, 2,  0);  // 6 rs2 not read
    vec(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, BR, 0, 2,  0);  // 7 branch beats load-use
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 2,  1);  // 8
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 2,  1);  // 9 mem wait 1
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 3,  1);  // 10
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 4,  1);  // 11
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, Z,  0, 5,  1);  // 12 release
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 5,  1);  // 13
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, Z,  0, 5,  1);  // 14 zero-wait access
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 5,  1);  // 15
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, FZ, 0, 5,  1);  // 16 branch suppressed
    vec(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 1, 0, 0, FZ, 0, 6,  1);  // 17 branch+lu suppressed
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, 0, BR, 0, 7,  1);  // 18 held branch flushes
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 7,  2);  // 19
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 7,  2);  // 20
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 8,  2);  // 21 abandoned access
    vec(1, 5'd9, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 0, LU, 0, 8,  2);  // 22 back in RUN
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 9,  2);  // 23 RUN -> MEM_WAIT
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 10, 2);  // 24 wait 1
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 11, 2);  // 25 wait 2
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 12, 2);  // 26 wait 3
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, FZ, 0, 13, 2);  // 27 wait 4 -> ERROR
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, FZ, 1, 14, 2);  // 28 ERROR sticky
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, FZ, 1, 15, 2);  // 29 ready ignored
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, FZ, 1, 15, 2);  // 30 saturated
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, FZ, 1, 15, 2);  // 31 clear vs stall
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, FZ, 1, 0,  0);  // 32
    vec(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 0,  0);  // 33 async reset
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 0,  0);  // 34
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1, BR, 0, 0,  0);  // 35 clear vs flush
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 0,  0);  // 36
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, BR, 0, 0,  0);  // 37
    vec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, Z,  0, 0,  1);  // 38
    done = 1;
  end

  initial begin
    int cyc;
    wait (done);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      @(posedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
